// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module : cmp_pkg
// Brief  : Shared result encoding for the three-way magnitude comparator.
// Rev    : 1.0  initial release
// ============================================================================
package cmp_pkg;

    // One-hot {greater, lower, equal}
    typedef logic [2:0] cmp_result_t;

    localparam cmp_result_t CMP_NONE = 3'b000;
    localparam cmp_result_t CMP_EQ   = 3'b001;
    localparam cmp_result_t CMP_LT   = 3'b010;
    localparam cmp_result_t CMP_GT   = 3'b100;

    function automatic cmp_result_t cmp_encode(input logic gt, input logic lt, input logic eq);
        cmp_result_t res;
        res = CMP_GT;
        if (eq) begin
            res = CMP_EQ;
        end else if (lt) begin
            res = CMP_LT;
        end else if (gt) begin
            res = CMP_GT;
        end
        return res;
    endfunction

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/cmp_bit_cell.sv
`default_nettype none
// ============================================================================
// Module : cmp_bit_cell
// Brief  : One stage of an MSB-first magnitude cascade; a decided gt/lt from
//          a more significant stage passes through untouched.
// Rev    : 1.0  initial release
// ============================================================================
module cmp_bit_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic gt_in,
    input  logic lt_in,
    input  logic eq_in,
    input  logic invert_sign,
    output logic gt_out,
    output logic lt_out,
    output logic eq_out
);

    logic w_bit_gt;
    logic w_bit_lt;

    // On a two's-complement sign bit a 1 means smaller, so the sense flips.
    assign w_bit_gt = invert_sign ? (~a_i &  b_i) : ( a_i & ~b_i);
    assign w_bit_lt = invert_sign ? ( a_i & ~b_i) : (~a_i &  b_i);

    assign gt_out = gt_in | (eq_in & w_bit_gt);
    assign lt_out = lt_in | (eq_in & w_bit_lt);
    assign eq_out = eq_in & ~(a_i ^ b_i);

endmodule : cmp_bit_cell
`default_nettype wire

// File: rtl/n_bit_comparator.sv
`default_nettype none
// ============================================================================
// Module : n_bit_comparator
// Brief  : Registered three-way (eq/lt/gt) compare of two WIDTH-bit operands,
//          unsigned or two's-complement, one-cycle latency with valid strobe.
// Rev    : 1.0  initial release
// ============================================================================
module n_bit_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             equal,
    output logic             lower,
    output logic             greater
);

    // Index WIDTH is the cascade seed; index 0 is the fully resolved result.
    logic [WIDTH:0] w_gt_chain;
    logic [WIDTH:0] w_lt_chain;
    logic [WIDTH:0] w_eq_chain;

    assign w_gt_chain[WIDTH] = 1'b0;
    assign w_lt_chain[WIDTH] = 1'b0;
    assign w_eq_chain[WIDTH] = 1'b1;

    generate
        for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_cell
            localparam bit C_INVERT = SIGNED && (i == WIDTH - 1);

            cmp_bit_cell u_cell (
                .a_i         (a[i]),
                .b_i         (b[i]),
                .gt_in       (w_gt_chain[i+1]),
                .lt_in       (w_lt_chain[i+1]),
                .eq_in       (w_eq_chain[i+1]),
                .invert_sign (C_INVERT),
                .gt_out      (w_gt_chain[i]),
                .lt_out      (w_lt_chain[i]),
                .eq_out      (w_eq_chain[i])
            );
        end
    endgenerate

    cmp_result_t result_d;
    cmp_result_t result_q;
    logic        valid_d;
    logic        valid_q;

    always_comb begin
        valid_d  = in_valid;
        result_d = result_q;
        // Operands are only looked at when in_valid is set, keeping X out of state.
        if (in_valid) begin
            result_d = cmp_encode(w_gt_chain[0], w_lt_chain[0], w_eq_chain[0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= CMP_NONE;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign out_valid = valid_q;
    assign greater   = result_q[2];
    assign lower     = result_q[1];
    assign equal     = result_q[0];

endmodule : n_bit_comparator
`default_nettype wire

// File: tb/tb_n_bit_comparator.sv
`default_nettype none
// ============================================================================
// Module : tb_n_bit_comparator
// Brief  : Scoreboard bench over unsigned-4, signed-4 and unsigned-32 instances.
// Rev    : 1.0  initial release
// ============================================================================
module tb_n_bit_comparator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        u_iv, u_ov, u_eq, u_lt, u_gt;
    logic [3:0]  u_a, u_b;
    logic        s_iv, s_ov, s_eq, s_lt, s_gt;
    logic [3:0]  s_a, s_b;
    logic        w_iv, w_ov, w_eq, w_lt, w_gt;
    logic [31:0] w_a, w_b;

    logic [2:0] qu[$];
    logic [2:0] qs[$];
    logic [2:0] qw[$];
    logic [2:0] u_exp, s_exp, w_exp;

    n_bit_comparator #(.WIDTH(4), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(u_iv), .a(u_a), .b(u_b),
        .out_valid(u_ov), .equal(u_eq), .lower(u_lt), .greater(u_gt));

    n_bit_comparator #(.WIDTH(4), .SIGNED(1'b1)) s_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .a(s_a), .b(s_b),
        .out_valid(s_ov), .equal(s_eq), .lower(s_lt), .greater(s_gt));

    n_bit_comparator #(.WIDTH(32), .SIGNED(1'b0)) w_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(w_iv), .a(w_a), .b(w_b),
        .out_valid(w_ov), .equal(w_eq), .lower(w_lt), .greater(w_gt));

    // Reference: plain integer ordering, returned as {gt, lt, eq}
    function automatic logic [2:0] ref_cmp(input longint x, input longint y);
        if (x > y) return 3'b100;
        if (x < y) return 3'b010;
        return 3'b001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {ov,gt,lt,eq}=%b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue_u(input logic [3:0] x, input logic [3:0] y);
        u_a = x; u_b = y; u_iv = 1'b1;
        qu.push_back(ref_cmp(longint'(x), longint'(y)));
        tick();
        u_iv = 1'b0;
    endtask

    task automatic issue_s(input logic [3:0] x, input logic [3:0] y);
        s_a = x; s_b = y; s_iv = 1'b1;
        qs.push_back(ref_cmp(longint'($signed(x)), longint'($signed(y))));
        tick();
        s_iv = 1'b0;
    endtask

    task automatic issue_w(input logic [31:0] x, input logic [31:0] y);
        w_a = x; w_b = y; w_iv = 1'b1;
        qw.push_back(ref_cmp(longint'(x), longint'(y)));
        tick();
        w_iv = 1'b0;
    endtask

    always @(negedge clk) begin
        if (u_ov) begin
            total++;
            if (qu.size() == 0) begin
                bad++;
                $display("FAIL u4_unexpected_valid: got out_valid=1 want no result");
            end else begin
                u_exp = qu.pop_front();
                if ({u_gt, u_lt, u_eq} !== u_exp) begin
                    bad++;
                    $display("FAIL u4_result: got {gt,lt,eq}=%b want %b", {u_gt, u_lt, u_eq}, u_exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (s_ov) begin
            total++;
            if (qs.size() == 0) begin
                bad++;
                $display("FAIL s4_unexpected_valid: got out_valid=1 want no result");
            end else begin
                s_exp = qs.pop_front();
                if ({s_gt, s_lt, s_eq} !== s_exp) begin
                    bad++;
                    $display("FAIL s4_result: got {gt,lt,eq}=%b want %b", {s_gt, s_lt, s_eq}, s_exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (w_ov) begin
            total++;
            if (qw.size() == 0) begin
                bad++;
                $display("FAIL w32_unexpected_valid: got out_valid=1 want no result");
            end else begin
                w_exp = qw.pop_front();
                if ({w_gt, w_lt, w_eq} !== w_exp) begin
                    bad++;
                    $display("FAIL w32_result: got {gt,lt,eq}=%b want %b", {w_gt, w_lt, w_eq}, w_exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        rst_n = 1'b0;
        u_iv = 1'b1; u_a = 4'd3; u_b = 4'd5;
        s_iv = 1'b0; s_a = '0; s_b = '0;
        w_iv = 1'b0; w_a = '0; w_b = '0;

        // Held in reset while in_valid is asserted: nothing may be captured.
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold_u4", {u_ov, u_gt, u_lt, u_eq}, 4'b0000);
        end
        chk("reset_hold_s4", {s_ov, s_gt, s_lt, s_eq}, 4'b0000);
        chk("reset_hold_w32", {w_ov, w_gt, w_lt, w_eq}, 4'b0000);
        u_iv = 1'b0;
        #2 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                issue_u(4'(i), 4'(j));
                u_iv = 1'b1;
            end
        end
        u_iv = 1'b0;
        tick();

        issue_u(4'd7, 4'd7);
        @(negedge clk); chk("spot_7_7_eq", {u_ov, u_gt, u_lt, u_eq}, 4'b1001);
        issue_u(4'd0, 4'd15);
        @(negedge clk); chk("spot_0_15_lt", {u_ov, u_gt, u_lt, u_eq}, 4'b1010);
        issue_u(4'd15, 4'd0);
        @(negedge clk); chk("spot_15_0_gt", {u_ov, u_gt, u_lt, u_eq}, 4'b1100);

        // Valid gap: last result persists through idle cycles with X operands.
        issue_u(4'd9, 4'd2);
        u_a = 'x; u_b = 'x;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("gap_hold_gt", {u_ov, u_gt, u_lt, u_eq}, 4'b0100);
        end

        // Asynchronous reset mid-cycle right after a capture.
        u_a = 4'd3; u_b = 4'd5; u_iv = 1'b1;
        qu.push_back(ref_cmp(64'd3, 64'd5));
        tick();
        u_iv = 1'b0;
        #2 rst_n = 1'b0;
        qu.delete();
        #1 chk("async_reset_clear", {u_ov, u_gt, u_lt, u_eq}, 4'b0000);
        #3 rst_n = 1'b1;
        tick();

        // Reset in the cycle after a capture; released with in_valid low.
        issue_u(4'd1, 4'd2);
        @(negedge clk); chk("midstream_capture_lt", {u_ov, u_gt, u_lt, u_eq}, 4'b1010);
        tick();
        #2 rst_n = 1'b0;
        qu.delete();
        #1 chk("midstream_reset", {u_ov, u_gt, u_lt, u_eq}, 4'b0000);
        tick();
        #2 rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("post_reset_idle", {u_ov, u_gt, u_lt, u_eq}, 4'b0000);
        end
        tick();

        issue_s(4'b1000, 4'b0111);
        @(negedge clk); chk("signed_m8_lt_p7", {s_ov, s_gt, s_lt, s_eq}, 4'b1010);
        issue_s(4'b1111, 4'b0000);
        @(negedge clk); chk("signed_m1_lt_0", {s_ov, s_gt, s_lt, s_eq}, 4'b1010);
        issue_s(4'b1111, 4'b1110);
        @(negedge clk); chk("signed_m1_gt_m2", {s_ov, s_gt, s_lt, s_eq}, 4'b1100);
        issue_s(4'b0000, 4'b0000);
        @(negedge clk); chk("signed_0_eq_0", {s_ov, s_gt, s_lt, s_eq}, 4'b1001);
        for (int k = 0; k < 60; k++) begin
            s_a = 4'($urandom);
            s_b = (k % 5 == 0) ? s_a : 4'($urandom);
            issue_s(s_a, s_b);
        end
        tick();

        issue_w(32'hFFFF_FFFF, 32'hFFFF_FFFE);
        @(negedge clk); chk("wide_max_gt", {w_ov, w_gt, w_lt, w_eq}, 4'b1100);
        issue_w(32'h8000_0000, 32'h8000_0000);
        @(negedge clk); chk("wide_msb_eq", {w_ov, w_gt, w_lt, w_eq}, 4'b1001);
        for (int k = 0; k < 80; k++) begin
            r   = $urandom;
            w_a = r;
            case (k % 4)
                0:       w_b = r;
                1:       w_b = r ^ (32'd1 << $urandom_range(31, 0));
                default: w_b = $urandom;
            endcase
            issue_w(w_a, w_b);
        end
        tick();
        tick();

        total++;
        if (qu.size() != 0 || qs.size() != 0 || qw.size() != 0) begin
            bad++;
            $display("FAIL pending_results: got u4=%0d s4=%0d w32=%0d outstanding want 0",
                     qu.size(), qs.size(), qw.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_n_bit_comparator
`default_nettype wire
